noc_port_arbiter: RTL and testbench

- Output-port stage directly downstream of the per-node n2p FIFOs in the NoC switch.
- Round-robin arbitrates among NUM_IN FIFOs; grant held for a whole packet (header + length-counted payload).
- Pops words with rd_en and drives one 9-bit output port, idle token 9'h100 between packets.
- Matches FIFO read timing: data registered, valid the cycle after rd_en.

---
 rtl/noc_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_noc_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/noc_port_arbiter.sv
// NoC output-port arbiter: round-robin over NUM_IN n2p FIFOs, grant held for a whole packet.
// Optional ARB_TIMEOUT_EN releases a grant whose payload stalls for TIMEOUT cycles.

module noc_port_arbiter_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             rst,
  input  logic [IDX_W-1:0] pick,
  input  logic             pick_vld,
  input  logic [IDX_W-1:0] grant,
  input  logic             pop_vld,
  output logic             rd_en
);
  assign rd_en = rst & ((pick_vld & (pick == IDX_W'(LANE))) |
                        (pop_vld  & (grant == IDX_W'(LANE))));
endmodule

module noc_port_arbiter #(
  parameter int DATA_WIDTH = 9,
  parameter int NUM_IN     = 4,
  parameter int IDX_W      = $clog2(NUM_IN),
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            fifo_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_IN-1:0]            fifo_rd_en,
  output logic [DATA_WIDTH-1:0]        port_out,
  output logic [IDX_W-1:0]             grant,
  output logic                         busy,
  output logic                         pkt_done,
  output logic                         pkt_err
);
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;

  localparam logic [DATA_WIDTH-1:0] IDLE_TOK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                             state;
  logic [IDX_W-1:0]                   rr_ptr;
  logic [7:0]                         rd_left, wr_left;
  logic                               rd_q;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0]  data_arr;
  logic [DATA_WIDTH-1:0]              cur;
  logic [7:0]                         len;
  logic                               cur_empty, hdr_ok, perr, tmo;
  logic                               found, pick_vld, grant_pop;
  logic [IDX_W-1:0]                   pick, rr_nxt;

  assign data_arr  = fifo_data;
  assign cur       = data_arr[grant];
  assign len       = cur[7:0];
  assign cur_empty = fifo_empty[grant];
  assign hdr_ok    = cur[DATA_WIDTH-1] && (len != 8'd0);
  assign perr      = (state == S_PAYLOAD) && rd_q && cur[DATA_WIDTH-1];
  assign rr_nxt    = (grant == IDX_W'(NUM_IN-1)) ? '0 : grant + IDX_W'(1);

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_IN.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end
    end
  end

  assign pick_vld = (state == S_IDLE) && found;

  always_comb begin
    grant_pop = 1'b0;
    case (state)
      S_HDR:     grant_pop = hdr_ok && !cur_empty;
      S_PAYLOAD: grant_pop = !cur_empty && (rd_left != 8'd0) && !perr && !tmo;
      default:   grant_pop = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    noc_port_arbiter_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
      .rst      (rst),
      .pick     (pick),
      .pick_vld (pick_vld),
      .grant    (grant),
      .pop_vld  (grant_pop),
      .rd_en    (fifo_rd_en[i])
    );
  end

`ifdef ARB_TIMEOUT_EN
  localparam int SW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  logic [SW-1:0] stall_cnt;

  // Counts consecutive payload cycles with nothing arriving from the FIFO.
  assign tmo = (state == S_PAYLOAD) && !rd_q && (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            stall_cnt <= '0;
    else if (state != S_PAYLOAD || rd_q) stall_cnt <= '0;
    else if (!tmo)                       stall_cnt <= stall_cnt + SW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      rd_left  <= '0;
      wr_left  <= '0;
      rd_q     <= 1'b0;
      port_out <= IDLE_TOK;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          port_out <= IDLE_TOK;
          rd_q     <= 1'b0;
          if (found) begin
            grant <= pick;
            state <= S_HDR;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        S_HDR: begin
          if (hdr_ok) begin
            port_out <= cur;
            // A payload word popped alongside the header already counts as read.
            rd_left  <= len - {7'd0, grant_pop};
            wr_left  <= len;
            rd_q     <= grant_pop;
            state    <= S_PAYLOAD;
            busy     <= 1'b1;
          end else begin
            port_out <= IDLE_TOK;
            rd_q     <= 1'b0;
            state    <= S_IDLE;
            busy     <= 1'b0;
            if (!cur[DATA_WIDTH-1]) begin
              pkt_err <= 1'b1;
              rr_ptr  <= rr_nxt;
            end
          end
        end
        S_PAYLOAD: begin
          rd_q <= grant_pop;
          if (grant_pop) rd_left <= rd_left - 8'd1;
          if (perr || tmo) begin
            port_out <= IDLE_TOK;
            pkt_err  <= 1'b1;
            rr_ptr   <= rr_nxt;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end else if (rd_q) begin
            port_out <= cur;
            wr_left  <= wr_left - 8'd1;
            if (wr_left == 8'd1) begin
              pkt_done <= 1'b1;
              rr_ptr   <= rr_nxt;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end
          end else begin
            port_out <= IDLE_TOK;
          end
        end
        default: begin
          state    <= S_IDLE;
          port_out <= IDLE_TOK;
          busy     <= 1'b0;
          rd_q     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter with a behavioural registered-output FIFO per input.
module tb_noc_port_arbiter;
  localparam int NI = 4;
  localparam int DW = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI-1:0]    fifo_empty;
  logic [NI*DW-1:0] fifo_data;
  logic [NI-1:0]    fifo_rd_en;
  logic [DW-1:0]    port_out;
  logic [1:0]       grant;
  logic             busy, pkt_done, pkt_err;

  int checks = 0;
  int errors = 0;

  noc_port_arbiter #(.DATA_WIDTH(DW), .NUM_IN(NI), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .port_out   (port_out),
    .grant      (grant),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  logic [8:0]    mem  [NI][64];
  int            wp   [NI] = '{default: 0};
  int            rp   [NI] = '{default: 0};
  logic [8:0]    dout [NI] = '{default: 9'h100};
  logic [NI-1:0] pend = '0;

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int i = 0; i < NI; i++) begin
      fifo_empty[i]        = (wp[i] == rp[i]);
      fifo_data[i*DW +: DW] = dout[i];
    end
  end

  // Pop requests are sampled mid-cycle and applied just after the edge.
  always @(negedge clk) pend <= fifo_rd_en;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++)
      if (pend[i] && rp[i] != wp[i]) begin
        dout[i] <= mem[i][rp[i]];
        rp[i]   <= rp[i] + 1;
      end
  end

  task automatic push(input int f, input logic [8:0] w);
    mem[f][wp[f]] = w;
    wp[f] = wp[f] + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    push(0, 9'h103); push(0, 9'h0AA); push(0, 9'h0BB); push(0, 9'h0CC);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_port", port_out, 9'h100);
      chk("rst_rden", fifo_rd_en, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant, 2'd0);
      chk("rst_done", pkt_done, 1'b0);
      chk("rst_err", pkt_err, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("rel_rden", fifo_rd_en, 4'b0001);

    // Single packet on FIFO0
    step(); chk("p0_busy", busy, 1'b1); chk("p0_grant", grant, 2'd0);
            chk("p0_port_hdr_cyc", port_out, 9'h100); chk("p0_rden", fifo_rd_en, 4'b0001);
    step(); chk("p0_hdr", port_out, 9'h103);
    step(); chk("p0_w0", port_out, 9'h0AA);
    step(); chk("p0_w1", port_out, 9'h0BB); chk("p0_done_early", pkt_done, 1'b0);
    step(); chk("p0_w2", port_out, 9'h0CC); chk("p0_done", pkt_done, 1'b1);
    step(); chk("p0_idle", port_out, 9'h100); chk("p0_done_clr", pkt_done, 1'b0);
            chk("p0_busy_clr", busy, 1'b0);

    // Round robin between FIFO1 and FIFO2
    push(1, 9'h101); push(1, 9'h011); push(2, 9'h101); push(2, 9'h022);
    #1; chk("rr_first", fifo_rd_en, 4'b0010);
    step(); chk("rr1_grant", grant, 2'd1);
    step(); chk("rr1_hdr", port_out, 9'h101);
    step(); chk("rr1_w", port_out, 9'h011); chk("rr1_done", pkt_done, 1'b1);
            chk("rr_second", fifo_rd_en, 4'b0100);
    push(1, 9'h101); push(1, 9'h033);
    step(); chk("rr2_grant", grant, 2'd2);
    step(); chk("rr2_hdr", port_out, 9'h101);
    step(); chk("rr2_w", port_out, 9'h022); chk("rr2_done", pkt_done, 1'b1);
            chk("rr_third", fifo_rd_en, 4'b0010);
    step(); chk("rr3_grant", grant, 2'd1);
    step(); chk("rr3_hdr", port_out, 9'h101);
    step(); chk("rr3_w", port_out, 9'h033); chk("rr3_done", pkt_done, 1'b1);
            chk("rr_none", fifo_rd_en, 4'b0000);

    // Underrun mid-packet on FIFO3
    push(3, 9'h102); push(3, 9'h044);
    #1; chk("ur_pick", fifo_rd_en, 4'b1000);
    step(); chk("ur_grant", grant, 2'd3);
    step(); chk("ur_hdr", port_out, 9'h102);
    step(); chk("ur_w0", port_out, 9'h044); chk("ur_rden0", fifo_rd_en, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ur_bubble", port_out, 9'h100);
      chk("ur_busy", busy, 1'b1);
      chk("ur_grant_held", grant, 2'd3);
      chk("ur_noerr", pkt_err, 1'b0);
      chk("ur_nodone", pkt_done, 1'b0);
      if (k == 3) push(3, 9'h055);
    end
    step(); chk("ur_w1", port_out, 9'h055); chk("ur_done", pkt_done, 1'b1);
            chk("ur_noerr_end", pkt_err, 1'b0);

    // Protocol errors: header inside payload, then orphan payload word
    push(0, 9'h103); push(0, 9'h105); push(0, 9'h033);
    #1; chk("pe_pick", fifo_rd_en, 4'b0001);
    step(); chk("pe_grant", grant, 2'd0);
    step(); chk("pe_hdr", port_out, 9'h103); chk("pe_nopop", fifo_rd_en, 4'b0000);
    step(); chk("pe_drop", port_out, 9'h100); chk("pe_err", pkt_err, 1'b1);
            chk("pe_busy", busy, 1'b0); chk("pe_repick", fifo_rd_en, 4'b0001);
    step(); chk("pe_err_clr", pkt_err, 1'b0); chk("or_busy", busy, 1'b1);
    step(); chk("or_err", pkt_err, 1'b1); chk("or_port", port_out, 9'h100);
            chk("or_busy_clr", busy, 1'b0);

    // All inputs empty: stays idle
    for (int k = 0; k < 2; k++) begin
      step(); chk("em_rden", fifo_rd_en, 4'b0000); chk("em_busy", busy, 1'b0);
              chk("em_err", pkt_err, 1'b0);
    end

    // Idle token where a header is expected: silently dropped
    push(2, 9'h100); push(2, 9'h101); push(2, 9'h0AB);
    #1; chk("it_pick", fifo_rd_en, 4'b0100);
    step(); chk("it_grant", grant, 2'd2); chk("it_nopop", fifo_rd_en, 4'b0000);
    step(); chk("it_port", port_out, 9'h100); chk("it_noerr", pkt_err, 1'b0);
            chk("it_busy", busy, 1'b0); chk("it_repick", fifo_rd_en, 4'b0100);
    step();
    step(); chk("it_hdr", port_out, 9'h101);
    step(); chk("it_w", port_out, 9'h0AB); chk("it_done", pkt_done, 1'b1);

`ifdef ARB_TIMEOUT_EN
    push(3, 9'h104); push(3, 9'h0D1); push(0, 9'h101); push(0, 9'h0D2);
    #1; chk("to_pick", fifo_rd_en, 4'b1000);
    step();
    step(); chk("to_hdr", port_out, 9'h104);
    step(); chk("to_w0", port_out, 9'h0D1);
    for (int k = 0; k < 15; k++) begin
      step(); chk("to_wait_err", pkt_err, 1'b0); chk("to_wait_busy", busy, 1'b1);
    end
    step(); chk("to_err", pkt_err, 1'b1); chk("to_busy", busy, 1'b0);
            chk("to_next", fifo_rd_en, 4'b0001);
    step(); chk("to_grant", grant, 2'd0);
    step(); chk("to_hdr2", port_out, 9'h101);
    step(); chk("to_w2", port_out, 9'h0D2); chk("to_done", pkt_done, 1'b1);
`endif

    // Reset in the middle of a packet
    push(1, 9'h103); push(1, 9'h0A1); push(1, 9'h0A2); push(1, 9'h0A3);
    #1; chk("mr_pick", fifo_rd_en, 4'b0010);
    step();
    step(); chk("mr_hdr", port_out, 9'h103);
    step(); chk("mr_w0", port_out, 9'h0A1);
    rst = 1'b0;
    #1;
    chk("mr_port", port_out, 9'h100);
    chk("mr_busy", busy, 1'b0);
    chk("mr_rden", fifo_rd_en, 4'b0000);
    chk("mr_grant", grant, 2'd0);
    step(); chk("mr_port_hold", port_out, 9'h100); chk("mr_rden_hold", fifo_rd_en, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
